// File: rtl/xbar_slave_port_arbiter_pkg.sv
// Shared constants, FSM state type and one-hot/index helpers for the XBAR bridge slave port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xbar_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned ID_W   = 9;
  localparam int unsigned AUX_W  = 8;
  // In-flight counter width; supports up to 15 outstanding transactions.
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Requester index -> one-hot transaction ID (zero-extended to ID_W).
  function automatic logic [ID_W-1:0] idx_to_onehot(input int unsigned idx);
    return ID_W'(1) << idx;
  endfunction

  // One-hot transaction ID -> lowest set requester index (0 if none set).
  function automatic int unsigned onehot_to_idx(input logic [ID_W-1:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = ID_W; i > 0; i--) begin
      if (oh[i-1]) r = i - 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xbar_slave_port_arbiter_if.sv
// Bundle of the requester-side and slave-side buses around the slave port arbiter.
// Latency: n/a (wires only).
// Backpressure: req/gnt on both sides; responses are not back-pressurable.
// Ports: m_* = N_MASTER bridge requesters (per-requester req/gnt/r_valid, broadcast response),
//        data_* = single memory-side slave port with one-hot request ID.
// Modport master is the arbiter's view (it masters the slave port); slave is the surroundings.
interface xbar_slave_port_arbiter_if
  import xbar_bridge_pkg::*;
#(
  parameter int unsigned N_MASTER = 4
) ();

  // Requester side
  logic [N_MASTER-1:0]             m_req_i;
  logic [N_MASTER-1:0][ADDR_W-1:0] m_add_i;
  logic [N_MASTER-1:0]             m_wen_i;
  logic [N_MASTER-1:0][DATA_W-1:0] m_wdata_i;
  logic [N_MASTER-1:0][BE_W-1:0]   m_be_i;
  logic [N_MASTER-1:0][AUX_W-1:0]  m_aux_i;
  logic [N_MASTER-1:0]             m_gnt_o;
  logic [N_MASTER-1:0]             m_r_valid_o;
  logic [DATA_W-1:0]               m_r_rdata_o;
  logic                            m_r_opc_o;
  logic [AUX_W-1:0]                m_r_aux_o;

  // Slave side
  logic                            data_req_o;
  logic [ADDR_W-1:0]               data_add_o;
  logic                            data_wen_o;
  logic [DATA_W-1:0]               data_wdata_o;
  logic [BE_W-1:0]                 data_be_o;
  logic [ID_W-1:0]                 data_ID_o;
  logic [AUX_W-1:0]                data_aux_o;
  logic                            data_gnt_i;
  logic                            data_r_valid_i;
  logic [DATA_W-1:0]               data_r_rdata_i;
  logic [ID_W-1:0]                 data_r_ID_i;
  logic                            data_r_opc_i;
  logic [AUX_W-1:0]                data_r_aux_i;

  modport master (
    input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i, m_aux_i,
    output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o, m_r_aux_o,
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o,
    input  data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_ID_i, data_r_opc_i, data_r_aux_i
  );

  modport slave (
    output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i, m_aux_i,
    input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o, m_r_aux_o,
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o,
    output data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_ID_i, data_r_opc_i, data_r_aux_i
  );

endinterface

// File: rtl/xbar_slave_port_arbiter_rr_arbiter.sv
// N-way round-robin pick: first requesting index at or after ptr, wrapping modulo N.
// Latency: purely combinational; the pointer register lives in the parent.
// Backpressure: none; vld=0 when no request bit is set.
// Ports: req (request vector), ptr (priority start index), vld (any pick), sel (picked index).
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             vld,
  output logic [SEL_W-1:0] sel
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    vld = 1'b0;
    sel = ptr;
    idx = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      idx = SEL_W'((32'(ptr) + i) % N);
      if (!vld && req[idx]) begin
        vld = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/xbar_slave_port_arbiter.sv
// Shares one memory slave port between N_MASTER requesters: round-robin pick, one-hot ID tag, response back-routing.
// Latency: zero added; request, grant and response routing are all combinational, only state/counters are registered.
// Backpressure: slave gnt low holds the chosen requester (HOLD); new picks stop while MAX_OUTST requests are in flight.
// Ports: clk, rst (sync, active high, forces all outputs to 0), bus (master modport),
//        outst_cnt_o (in-flight count), err_o (sticky protocol error, cleared only by rst).
module xbar_slave_port_arbiter
  import xbar_bridge_pkg::*;
#(
  parameter int unsigned N_MASTER  = 4,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  xbar_slave_port_arbiter_if.master  bus,
  output logic [CNT_W-1:0]           outst_cnt_o,
  output logic                       err_o
);

  localparam int unsigned SEL_W   = $clog2(N_MASTER);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(N_MASTER - 1);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] outst_q;
  logic             err_q;

  logic             arb_vld;
  logic [SEL_W-1:0] arb_sel;
  logic [SEL_W-1:0] cur_sel;
  logic             req_act;
  logic             accept;
  logic             hold_drop;
  logic             full;
  logic             resp_ok;
  logic             resp_err;

  rr_arbiter #(.N(N_MASTER)) u_rr (
    .req (bus.m_req_i),
    .ptr (rr_ptr_q),
    .vld (arb_vld),
    .sel (arb_sel)
  );

  assign full = (outst_q == MAX_CNT);

  // Which requester is presented this cycle. A HOLD keeps its requester even when
  // full or when others request, so address/data stay stable until the grant.
  // If the held requester withdraws, the slave request is dropped with it.
  always_comb begin
    cur_sel = arb_sel;
    req_act = 1'b0;
    case (state_q)
      IDLE: req_act = arb_vld && !full;
      HOLD: begin
        cur_sel = sel_q;
        req_act = bus.m_req_i[sel_q];
      end
      default: req_act = 1'b0;
    endcase
    if (rst) req_act = 1'b0;
  end

  assign accept = req_act && bus.data_gnt_i;

  // A response is only routed when something is in flight and it names a real requester.
  assign resp_ok  = bus.data_r_valid_i && (outst_q != '0) && (|bus.data_r_ID_i[N_MASTER-1:0]);
  assign resp_err = bus.data_r_valid_i && !resp_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hold_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_act && !bus.data_gnt_i) begin
          state_d = HOLD;
          sel_d   = cur_sel;
        end
      end
      HOLD: begin
        if (!bus.m_req_i[sel_q]) begin
          state_d   = IDLE;
          hold_drop = 1'b1;
        end else if (bus.data_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.data_req_o   = 1'b0;
    bus.data_add_o   = '0;
    bus.data_wen_o   = 1'b0;
    bus.data_wdata_o = '0;
    bus.data_be_o    = '0;
    bus.data_ID_o    = '0;
    bus.data_aux_o   = '0;
    bus.m_gnt_o      = '0;
    bus.m_r_valid_o  = '0;
    bus.m_r_rdata_o  = '0;
    bus.m_r_opc_o    = 1'b0;
    bus.m_r_aux_o    = '0;
    if (!rst) begin
      bus.data_req_o = req_act;
      if (req_act) begin
        bus.data_add_o   = bus.m_add_i[cur_sel];
        bus.data_wen_o   = bus.m_wen_i[cur_sel];
        bus.data_wdata_o = bus.m_wdata_i[cur_sel];
        bus.data_be_o    = bus.m_be_i[cur_sel];
        bus.data_aux_o   = bus.m_aux_i[cur_sel];
        bus.data_ID_o    = idx_to_onehot(32'(cur_sel));
      end
      bus.m_gnt_o[cur_sel] = accept;
      bus.m_r_valid_o      = resp_ok ? bus.data_r_ID_i[N_MASTER-1:0] : '0;
      bus.m_r_rdata_o      = bus.data_r_rdata_i;
      bus.m_r_opc_o        = bus.data_r_opc_i;
      bus.m_r_aux_o        = bus.data_r_aux_i;
    end
  end

  // Pointer, in-flight counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) rr_ptr_q <= (cur_sel == LAST) ? '0 : cur_sel + SEL_W'(1);
      case ({accept, resp_ok})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
      if (hold_drop || resp_err) err_q <= 1'b1;
    end
  end

  assign outst_cnt_o = rst ? '0 : outst_q;
  assign err_o       = rst ? 1'b0 : err_q;

  // ID bits above the requester count carry no routing meaning.
  generate
    if (N_MASTER < ID_W) begin : g_id_hi
      logic unused_id_hi;
      assign unused_id_hi = ^bus.data_r_ID_i[ID_W-1:N_MASTER];
    end
  endgenerate

endmodule

// File: tb/tb_xbar_slave_port_arbiter.sv
// Bench for the slave port arbiter: directed scenarios plus a randomized run against a queue-based reference model.
// Latency: inputs applied 1 time unit after posedge, combinational outputs sampled on negedge.
// Backpressure: random slave grant stalls and in-order slave responses from a queue.
module tb_xbar_slave_port_arbiter;
  import xbar_bridge_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] outst_cnt;
  logic       err;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  xbar_slave_port_arbiter_if #(.N_MASTER(N)) bus ();

  xbar_slave_port_arbiter #(.N_MASTER(N), .MAX_OUTST(MAXO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .outst_cnt_o (outst_cnt),
    .err_o       (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic clr_in;
    bus.m_req_i        = '0;
    bus.m_add_i        = '0;
    bus.m_wen_i        = '0;
    bus.m_wdata_i      = '0;
    bus.m_be_i         = '0;
    bus.m_aux_i        = '0;
    bus.data_gnt_i     = 1'b0;
    bus.data_r_valid_i = 1'b0;
    bus.data_r_rdata_i = '0;
    bus.data_r_ID_i    = '0;
    bus.data_r_opc_i   = 1'b0;
    bus.data_r_aux_i   = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr_in();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clr_in();
    bus.m_req_i        = 4'hF;
    bus.data_gnt_i     = 1'b1;
    bus.data_r_valid_i = 1'b1;
    bus.data_r_ID_i    = 9'h001;
    bus.data_r_rdata_i = 32'hFFFF_FFFF;
    samp();
    total++; if (bus.data_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", bus.data_req_o); end
    total++; if (bus.m_gnt_o !== 4'h0) begin bad++; $display("FAIL rst_gnt got=%0h want=0", bus.m_gnt_o); end
    total++; if (bus.m_r_valid_o !== 4'h0) begin bad++; $display("FAIL rst_rvalid got=%0h want=0", bus.m_r_valid_o); end
    total++; if (bus.m_r_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h want=0", bus.m_r_rdata_o); end
    total++; if (bus.data_ID_o !== 9'h0) begin bad++; $display("FAIL rst_id got=%0h want=0", bus.data_ID_o); end
    total++; if (outst_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", outst_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h want=0", err); end
    tick();
    clr_in();
    rst = 1'b0;
  endtask

  task automatic test_single;
    bus.m_req_i    = 4'b0001;
    bus.m_add_i[0] = 32'h1000_0040;
    bus.m_wen_i[0] = 1'b1;
    bus.data_gnt_i = 1'b1;
    samp();
    total++; if (bus.data_req_o !== 1'b1) begin bad++; $display("FAIL single_req got=%0h want=1", bus.data_req_o); end
    total++; if (bus.data_ID_o !== 9'h001) begin bad++; $display("FAIL single_id got=%0h want=001", bus.data_ID_o); end
    total++; if (bus.m_gnt_o !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%0h want=1", bus.m_gnt_o); end
    total++; if (bus.data_add_o !== 32'h1000_0040) begin bad++; $display("FAIL single_add got=%0h want=10000040", bus.data_add_o); end
    total++; if (bus.data_wen_o !== 1'b1) begin bad++; $display("FAIL single_wen got=%0h want=1", bus.data_wen_o); end
    total++; if (outst_cnt !== 4'd0) begin bad++; $display("FAIL single_cnt0 got=%0d want=0", outst_cnt); end
    tick();
    clr_in();
    bus.data_r_valid_i = 1'b1;
    bus.data_r_ID_i    = 9'h001;
    bus.data_r_rdata_i = 32'hDEAD_BEEF;
    samp();
    total++; if (outst_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt1 got=%0d want=1", outst_cnt); end
    total++; if (bus.m_r_valid_o !== 4'b0001) begin bad++; $display("FAIL single_rvalid got=%0h want=1", bus.m_r_valid_o); end
    total++; if (bus.m_r_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rdata got=%0h want=deadbeef", bus.m_r_rdata_o); end
    tick();
    clr_in();
    samp();
    total++; if (outst_cnt !== 4'd0) begin bad++; $display("FAIL single_cnt_back got=%0d want=0", outst_cnt); end
    tick();
  endtask

  task automatic test_rr_fair;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.m_req_i        = 4'hF;
      bus.data_gnt_i     = 1'b1;
      bus.data_r_valid_i = (k > 0);
      bus.data_r_ID_i    = (k > 0) ? 9'(1 << ((k - 1) % N)) : 9'h0;
      samp();
      total++; if (bus.m_gnt_o !== 4'(1 << (k % N))) begin bad++; $display("FAIL rr_gnt[%0d] got=%0h want=%0h", k, bus.m_gnt_o, 4'(1 << (k % N))); end
      total++; if (bus.data_ID_o !== 9'(1 << (k % N))) begin bad++; $display("FAIL rr_id[%0d] got=%0h want=%0h", k, bus.data_ID_o, 9'(1 << (k % N))); end
      total++; if (outst_cnt !== ((k == 0) ? 4'd0 : 4'd1)) begin bad++; $display("FAIL rr_cnt[%0d] got=%0d", k, outst_cnt); end
      if (k > 0) begin
        total++; if (bus.m_r_valid_o !== 4'(1 << ((k - 1) % N))) begin bad++; $display("FAIL rr_rvalid[%0d] got=%0h want=%0h", k, bus.m_r_valid_o, 4'(1 << ((k - 1) % N))); end
      end
      tick();
    end
    clr_in();
  endtask

  task automatic test_stall;
    do_reset();
    bus.m_add_i[0] = 32'h0000_0AAA;
    bus.m_add_i[1] = 32'h1111_0000;
    bus.m_add_i[2] = 32'h2222_0000;
    bus.m_req_i    = 4'b0110;
    bus.data_gnt_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) bus.m_req_i = 4'b0111;
      samp();
      total++; if (bus.data_req_o !== 1'b1) begin bad++; $display("FAIL stall_req[%0d] got=%0h want=1", c, bus.data_req_o); end
      total++; if (bus.data_ID_o !== 9'h002) begin bad++; $display("FAIL stall_id[%0d] got=%0h want=002", c, bus.data_ID_o); end
      total++; if (bus.data_add_o !== 32'h1111_0000) begin bad++; $display("FAIL stall_add[%0d] got=%0h want=11110000", c, bus.data_add_o); end
      total++; if (bus.m_gnt_o !== 4'h0) begin bad++; $display("FAIL stall_gnt[%0d] got=%0h want=0", c, bus.m_gnt_o); end
      tick();
    end
    bus.data_gnt_i = 1'b1;
    samp();
    total++; if (bus.m_gnt_o !== 4'b0010) begin bad++; $display("FAIL stall_release got=%0h want=2", bus.m_gnt_o); end
    tick();
    bus.m_req_i = 4'b0101;
    samp();
    total++; if (bus.m_gnt_o !== 4'b0100) begin bad++; $display("FAIL stall_next got=%0h want=4", bus.m_gnt_o); end
    total++; if (bus.data_add_o !== 32'h2222_0000) begin bad++; $display("FAIL stall_next_add got=%0h want=22220000", bus.data_add_o); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL stall_err got=%0h want=0", err); end
    tick();
    clr_in();
  endtask

  task automatic test_outst_limit;
    do_reset();
    bus.m_req_i    = 4'b0001;
    bus.data_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      samp();
      total++; if (bus.data_req_o !== 1'b1) begin bad++; $display("FAIL lim_req[%0d] got=%0h want=1", k, bus.data_req_o); end
      total++; if (outst_cnt !== 4'(k)) begin bad++; $display("FAIL lim_cnt[%0d] got=%0d want=%0d", k, outst_cnt, k); end
      tick();
    end
    samp();
    total++; if (bus.data_req_o !== 1'b0) begin bad++; $display("FAIL lim_full_req got=%0h want=0", bus.data_req_o); end
    total++; if (bus.m_gnt_o !== 4'h0) begin bad++; $display("FAIL lim_full_gnt got=%0h want=0", bus.m_gnt_o); end
    total++; if (outst_cnt !== 4'd4) begin bad++; $display("FAIL lim_full_cnt got=%0d want=4", outst_cnt); end
    tick();
    bus.data_r_valid_i = 1'b1;
    bus.data_r_ID_i    = 9'h001;
    samp();
    total++; if (bus.data_req_o !== 1'b0) begin bad++; $display("FAIL lim_resp_req got=%0h want=0", bus.data_req_o); end
    total++; if (bus.m_r_valid_o !== 4'b0001) begin bad++; $display("FAIL lim_resp_rvalid got=%0h want=1", bus.m_r_valid_o); end
    tick();
    bus.data_r_valid_i = 1'b0;
    samp();
    total++; if (outst_cnt !== 4'd3) begin bad++; $display("FAIL lim_resume_cnt got=%0d want=3", outst_cnt); end
    total++; if (bus.m_gnt_o !== 4'b0001) begin bad++; $display("FAIL lim_resume_gnt got=%0h want=1", bus.m_gnt_o); end
    tick();
    clr_in();
  endtask

  task automatic test_simul;
    do_reset();
    bus.m_req_i    = 4'b0001;
    bus.data_gnt_i = 1'b1;
    tick();
    tick();
    bus.data_r_valid_i = 1'b1;
    bus.data_r_ID_i    = 9'h001;
    samp();
    total++; if (outst_cnt !== 4'd2) begin bad++; $display("FAIL simul_pre got=%0d want=2", outst_cnt); end
    total++; if (bus.m_gnt_o !== 4'b0001) begin bad++; $display("FAIL simul_gnt got=%0h want=1", bus.m_gnt_o); end
    tick();
    clr_in();
    samp();
    total++; if (outst_cnt !== 4'd2) begin bad++; $display("FAIL simul_post got=%0d want=2", outst_cnt); end
    tick();
  endtask

  task automatic test_errors;
    // Response with nothing in flight
    do_reset();
    bus.data_r_valid_i = 1'b1;
    bus.data_r_ID_i    = 9'h001;
    samp();
    total++; if (bus.m_r_valid_o !== 4'h0) begin bad++; $display("FAIL err_empty_rvalid got=%0h want=0", bus.m_r_valid_o); end
    tick();
    clr_in();
    samp();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_empty got=%0h want=1", err); end
    total++; if (outst_cnt !== 4'd0) begin bad++; $display("FAIL err_empty_cnt got=%0d want=0", outst_cnt); end
    tick();
    do_reset();
    samp();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%0h want=0", err); end
    tick();
    // Response naming no requester
    bus.m_req_i    = 4'b0001;
    bus.data_gnt_i = 1'b1;
    tick();
    clr_in();
    bus.data_r_valid_i = 1'b1;
    bus.data_r_ID_i    = 9'h010;
    samp();
    total++; if (bus.m_r_valid_o !== 4'h0) begin bad++; $display("FAIL err_badid_rvalid got=%0h want=0", bus.m_r_valid_o); end
    tick();
    clr_in();
    samp();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_badid got=%0h want=1", err); end
    total++; if (outst_cnt !== 4'd1) begin bad++; $display("FAIL err_badid_cnt got=%0d want=1", outst_cnt); end
    tick();
    // Requester withdraws while held
    do_reset();
    bus.m_req_i = 4'b0010;
    samp();
    total++; if (bus.data_req_o !== 1'b1) begin bad++; $display("FAIL err_drop_req got=%0h want=1", bus.data_req_o); end
    tick();
    bus.m_req_i = 4'b0000;
    tick();
    samp();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_drop got=%0h want=1", err); end
    tick();
    // Reset in the middle of a HOLD, then a stale response
    do_reset();
    bus.m_req_i = 4'b0001;
    tick();
    rst = 1'b1;
    samp();
    total++; if (bus.data_req_o !== 1'b0) begin bad++; $display("FAIL err_rsthold_req got=%0h want=0", bus.data_req_o); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_rsthold_err got=%0h want=0", err); end
    tick();
    rst = 1'b0;
    clr_in();
    bus.data_r_valid_i = 1'b1;
    bus.data_r_ID_i    = 9'h001;
    samp();
    total++; if (bus.m_r_valid_o !== 4'h0) begin bad++; $display("FAIL err_stale_rvalid got=%0h want=0", bus.m_r_valid_o); end
    tick();
    clr_in();
    samp();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_stale got=%0h want=1", err); end
    tick();
  endtask

  // Random traffic: requesters hold requests until granted, the slave grants randomly
  // and answers in order from a queue of accepted tags.
  task automatic test_random;
    logic [N-1:0] req_v;
    logic [8:0]   q[$];
    int           ptr, hsel, sel;
    bit           held, exp_req, exp_acc, rv;
    logic [8:0]   rid;
    logic [31:0]  rdat;

    do_reset();
    req_v = '0;
    ptr   = 0;
    held  = 0;
    hsel  = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && ($urandom_range(0, 1) == 1)) begin
          req_v[i]         = 1'b1;
          bus.m_add_i[i]   = $urandom;
          bus.m_wdata_i[i] = $urandom;
          bus.m_wen_i[i]   = 1'($urandom_range(0, 1));
          bus.m_be_i[i]    = 4'($urandom_range(0, 15));
          bus.m_aux_i[i]   = 8'($urandom_range(0, 255));
        end
      end
      rv   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      rid  = rv ? q[0] : 9'h0;
      rdat = $urandom;
      bus.m_req_i        = req_v;
      bus.data_gnt_i     = ($urandom_range(0, 9) < 7);
      bus.data_r_valid_i = rv;
      bus.data_r_ID_i    = rid;
      bus.data_r_rdata_i = rdat;
      bus.data_r_aux_i   = 8'($urandom_range(0, 255));

      exp_req = 0;
      sel     = 0;
      if (held) begin
        sel     = hsel;
        exp_req = req_v[hsel];
      end else if (q.size() < MAXO) begin
        for (int j = N - 1; j >= 0; j--) begin
          if (req_v[(ptr + j) % N]) begin
            exp_req = 1;
            sel     = (ptr + j) % N;
          end
        end
      end
      exp_acc = exp_req && bus.data_gnt_i;

      samp();
      total++; if (bus.data_req_o !== exp_req) begin bad++; $display("FAIL rnd_req[%0d] got=%0h want=%0h", cyc, bus.data_req_o, exp_req); end
      total++; if (bus.m_gnt_o !== (exp_acc ? 4'(1 << sel) : 4'h0)) begin bad++; $display("FAIL rnd_gnt[%0d] got=%0h sel=%0d acc=%0d", cyc, bus.m_gnt_o, sel, exp_acc); end
      if (exp_req) begin
        total++; if (bus.data_ID_o !== 9'(1 << sel)) begin bad++; $display("FAIL rnd_id[%0d] got=%0h want=%0h", cyc, bus.data_ID_o, 9'(1 << sel)); end
        total++; if (bus.data_add_o !== bus.m_add_i[sel] || bus.data_wdata_o !== bus.m_wdata_i[sel] || bus.data_be_o !== bus.m_be_i[sel]) begin bad++; $display("FAIL rnd_fields[%0d] got_add=%0h want_add=%0h", cyc, bus.data_add_o, bus.m_add_i[sel]); end
      end
      total++; if (bus.m_r_valid_o !== (rv ? rid[3:0] : 4'h0)) begin bad++; $display("FAIL rnd_rvalid[%0d] got=%0h want=%0h", cyc, bus.m_r_valid_o, rid[3:0]); end
      if (rv) begin
        total++; if (bus.m_r_rdata_o !== rdat) begin bad++; $display("FAIL rnd_rdata[%0d] got=%0h want=%0h", cyc, bus.m_r_rdata_o, rdat); end
      end
      total++; if (outst_cnt !== 4'(q.size())) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d want=%0d", cyc, outst_cnt, q.size()); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err[%0d] got=%0h want=0", cyc, err); end

      if (rv) void'(q.pop_front());
      if (exp_acc) begin
        q.push_back(9'(1 << sel));
        ptr        = (sel + 1) % N;
        held       = 0;
        req_v[sel] = 1'b0;
      end else if (exp_req) begin
        held = 1;
        hsel = sel;
      end
      tick();
    end
    clr_in();
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    test_reset();
    test_single();
    test_rr_fair();
    test_stall();
    test_outst_limit();
    test_simul();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xbar_slave_port_arbiter.md
Name: xbar_slave_port_arbiter

Overview:
- Shares one memory-side slave port (req/gnt + r_valid response channel, 9-bit ID, 8-bit aux) between N_MASTER bridge-side requesters.
- Round-robin arbitration; request held stable until granted; outstanding-transaction limit.
- Tags each granted request with a one-hot requester ID; back-routes responses by r_ID.
- Sits between the bridge master ports and one slave port of the XBAR bridge.

Parameters:
- N_MASTER, 4, number of requesters (2..ID_W)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- ID_W, 9, transaction ID width
- AUX_W, 8, aux sideband width
- MAX_OUTST, 4, max in-flight requests (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_req_i  in  N_MASTER  per-requester request
- m_add_i  in  N_MASTER x ADDR_W  request address
- m_wen_i  in  N_MASTER  0 = store, 1 = load
- m_wdata_i  in  N_MASTER x DATA_W  write data
- m_be_i  in  N_MASTER x BE_W  byte enables
- m_aux_i  in  N_MASTER x AUX_W  aux sideband
- m_gnt_o  out  N_MASTER  per-requester grant
- m_r_valid_o  out  N_MASTER  per-requester response valid
- m_r_rdata_o  out  DATA_W  response data, broadcast
- m_r_opc_o  out  1  response opcode/error, broadcast
- m_r_aux_o  out  AUX_W  response aux, broadcast
- data_req_o  out  1  slave request
- data_add_o  out  ADDR_W  slave address
- data_wen_o  out  1  slave wen
- data_wdata_o  out  DATA_W  slave write data
- data_be_o  out  BE_W  slave byte enables
- data_ID_o  out  ID_W  one-hot requester tag
- data_aux_o  out  AUX_W  slave aux
- data_gnt_i  in  1  slave grant
- data_r_valid_i  in  1  slave response valid
- data_r_rdata_i  in  DATA_W  slave response data
- data_r_ID_i  in  ID_W  slave response ID
- data_r_opc_i  in  1  slave response opcode
- data_r_aux_i  in  AUX_W  slave response aux
- outst_cnt_o  out  4  in-flight count
- err_o  out  1  sticky protocol error

Behaviour:
- One clock, clk. Synchronous active-high reset rst.
- Reset values: rr_ptr=0, sel=0, state=IDLE, outst_cnt=0, err_o=0. While rst=1, all outputs are forced to 0.
- FSM IDLE:
  - If any m_req_i=1 and outst_cnt<MAX_OUTST, pick the first requesting index at or after rr_ptr (wrapping modulo N_MASTER).
  - Drive data_req_o=1 combinationally in the same cycle.
  - If data_gnt_i=1, stay in IDLE. Otherwise go to HOLD with sel latched.
- FSM HOLD:
  - Drive the latched sel regardless of other requests, so address and data stay stable until grant.
  - On data_gnt_i=1, return to IDLE.
  - If m_req_i[sel] drops before grant, set err_o=1 and return to IDLE.
- Grant:
  - m_gnt_o[sel] = data_req_o & data_gnt_i, combinational, so zero added latency.
  - On grant, rr_ptr <= (sel+1) mod N_MASTER.
- Slave fields are muxed from the selected requester. data_ID_o = one-hot(sel), zero-extended to ID_W.
- Full condition: when outst_cnt==MAX_OUTST, data_req_o=0 and no new selection is made. A HOLD already in progress keeps asserting its request.
- Counter:
  - +1 on accepted request (data_req_o & data_gnt_i).
  - -1 on data_r_valid_i.
  - Both in the same cycle: unchanged.
- Response routing:
  - m_r_valid_o[i] = data_r_valid_i & data_r_ID_i[i], same cycle.
  - rdata/opc/aux are passed through combinationally.
- Protocol errors: data_r_valid_i with outst_cnt==0, or with data_r_ID_i[N_MASTER-1:0]==0, sets err_o. The counter does not underflow, and no m_r_valid_o is raised.
- err_o clears only on rst.
- Reset mid-HOLD: drops the request immediately. In-flight responses arriving after reset set err_o.

Decomposition:
- Package xbar_bridge_pkg: width constants (ADDR_W, DATA_W, BE_W, ID_W, AUX_W), state enum {IDLE, HOLD}, one-hot/index conversion functions.
- Sub-module rr_arbiter: N-way round-robin priority pick from a request vector and pointer. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single master: m_req_i=0001, add 0x1000_0040, wen=1, gnt=1 -> same-cycle data_req_o=1, data_ID_o=9'h001, m_gnt_o=0001, outst_cnt 0->1. r_valid with ID 9'h001 and rdata 0xDEADBEEF -> m_r_valid_o=0001, count back to 0.
- Round-robin fairness: m_req_i=1111 held, gnt=1 every cycle, immediate responses -> grants in order 0,1,2,3,0; no starvation.
- Grant stall: m_req_i=0110 with gnt=0 for 3 cycles -> sel=1 held, data_add_o stable. m_req_i[0] rising during the stall does not steal; next grant goes to 2.
- Outstanding limit: MAX_OUTST=4, 4 grants without responses -> data_req_o=0 on the 5th cycle. One r_valid -> count 3, request resumes the next cycle.
- Simultaneous accept and response with count 2 -> count stays 2.
- Errors: r_valid with count 0 -> err_o=1 and no m_r_valid_o. Requester drops req in HOLD -> err_o=1. rst -> err_o=0, outputs 0.
